missile_unit: RTL

Player-shot manager for the Galaga display pipeline. It sits between the rocket-movement logic and the pixel colour generator. It launches shots from the rocket's nose on fire-key presses and advances each live shot upward once per frame. Each pixel it reports whether the current raster position (x, y) falls on any live shot. The colour generator ORs that flag with the rocket pixel.

---
 rtl/missile_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/missile_unit.sv
// missile_unit: player-shot manager for the Galaga display pipeline.
// Launches shots from the rocket nose on fire presses, moves live shots up
// once per frame, and flags raster pixels that fall on a live shot.
module missile_unit #(
  parameter int unsigned NSHOTS   = 4,
  parameter int unsigned SPEED    = 4,
  parameter int unsigned COOLDOWN = 8,
  parameter int unsigned SHOT_W   = 2,
  parameter int unsigned SHOT_H   = 6,
  parameter int unsigned NOSE_OFS = 5
) (
  input  logic              vgaclk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              fire,
  input  logic [9:0]        shipx,
  input  logic [9:0]        shipy,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic              spixel,
  output logic [NSHOTS-1:0] active,
  output logic              fired
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  // vsync synchronizer and edge register (all reset high: no tick out of reset)
  logic vs_meta_q, vs_sync_q, vs_prev_q;
  logic tick;

  // fire synchronizer, edge register and sample-valid pipeline
  logic       fire_meta_q, fire_sync_q, fire_prev_q;
  logic [1:0] fire_fill_q;
  logic       fire_edge;

  // shot slots and launch bookkeeping
  logic [NSHOTS-1:0]  valid_q, valid_d;
  logic [COORD_W-1:0] sx_q [NSHOTS];
  logic [COORD_W-1:0] sx_d [NSHOTS];
  logic [COORD_W-1:0] sy_q [NSHOTS];
  logic [COORD_W-1:0] sy_d [NSHOTS];
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               pending_q, pending_d;
  logic               fired_q, fired_d;

  // intermediate results of the move step
  logic [NSHOTS-1:0]  mv_valid;
  logic [COORD_W-1:0] mv_sy [NSHOTS];
  logic               free_found;
  logic               launch_ok;
  logic               slot_taken;

  // Synchronize vsync and detect the end of the sync pulse.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign tick = vs_sync_q & ~vs_prev_q;

  // Synchronize fire; the edge register holds high until the synchronizer
  // carries a real pin sample, so a key held through reset makes no edge.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      fire_meta_q <= 1'b0;
      fire_sync_q <= 1'b0;
      fire_prev_q <= 1'b1;
      fire_fill_q <= 2'b00;
    end else begin
      fire_meta_q <= fire;
      fire_sync_q <= fire_meta_q;
      fire_prev_q <= fire_fill_q[1] ? fire_sync_q : 1'b1;
      fire_fill_q <= {fire_fill_q[0], 1'b1};
    end
  end

  assign fire_edge = fire_sync_q & ~fire_prev_q;

  // Move step: shots rise by SPEED and drop out past the top edge.
  always_comb begin
    mv_valid = valid_q;
    for (int unsigned i = 0; i < NSHOTS; i++) begin
      mv_sy[i] = sy_q[i];
      if (valid_q[i]) begin
        if (sy_q[i] < COORD_W'(SPEED)) begin
          mv_valid[i] = 1'b0;
        end else begin
          mv_sy[i] = sy_q[i] - COORD_W'(SPEED);
        end
      end
    end
  end

  // Launch decision: a slot freed by this tick's move step is usable.
  always_comb begin
    free_found = 1'b0;
    for (int unsigned i = 0; i < NSHOTS; i++) begin
      if (!mv_valid[i]) begin
        free_found = 1'b1;
      end
    end
    launch_ok = tick & pending_q & (cd_q == '0) &
                (shipy >= COORD_W'(SHOT_H)) & free_found;
  end

  // Next-state for slots, cooldown, pending and the fired pulse.
  always_comb begin
    valid_d    = valid_q;
    cd_d       = cd_q;
    pending_d  = pending_q;
    fired_d    = 1'b0;
    slot_taken = 1'b0;
    for (int unsigned i = 0; i < NSHOTS; i++) begin
      sx_d[i] = sx_q[i];
      sy_d[i] = sy_q[i];
    end

    if (tick) begin
      valid_d = mv_valid;
      for (int unsigned i = 0; i < NSHOTS; i++) begin
        sy_d[i] = mv_sy[i];
      end
      // Lowest-index free slot takes the new shot, unmoved this tick.
      for (int unsigned i = 0; i < NSHOTS; i++) begin
        if (launch_ok && !mv_valid[i] && !slot_taken) begin
          slot_taken = 1'b1;
          valid_d[i] = 1'b1;
          sx_d[i]    = shipx + COORD_W'(NOSE_OFS);
          sy_d[i]    = shipy - COORD_W'(SHOT_H);
        end
      end
      if (launch_ok) begin
        cd_d    = CD_W'(COOLDOWN);
        fired_d = 1'b1;
      end else if (cd_q != '0) begin
        cd_d = cd_q - CD_W'(1);
      end
      // Tick clears pending and wins over a same-cycle fire edge.
      pending_d = 1'b0;
    end else if (fire_edge) begin
      pending_d = 1'b1;
    end
  end

  // Slot, cooldown and pulse registers.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      cd_q      <= '0;
      pending_q <= 1'b0;
      fired_q   <= 1'b0;
      for (int unsigned i = 0; i < NSHOTS; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      cd_q      <= cd_d;
      pending_q <= pending_d;
      fired_q   <= fired_d;
      for (int unsigned i = 0; i < NSHOTS; i++) begin
        sx_q[i] <= sx_d[i];
        sy_q[i] <= sy_d[i];
      end
    end
  end

  // Pixel hit test; 11-bit upper bounds so shots never wrap at the edges.
  always_comb begin
    spixel = 1'b0;
    for (int unsigned i = 0; i < NSHOTS; i++) begin
      if (valid_q[i] &&
          (x >= sx_q[i]) && ({1'b0, x} < ({1'b0, sx_q[i]} + 11'(SHOT_W))) &&
          (y >= sy_q[i]) && ({1'b0, y} < ({1'b0, sy_q[i]} + 11'(SHOT_H)))) begin
        spixel = 1'b1;
      end
    end
  end

  assign active = valid_q;
  assign fired  = fired_q;

endmodule
